stall_ctrl: RTL and testbench

STALL_CTRL -- requirements
Module: stall_ctrl

---
 rtl/stall_ctrl_if.sv | 39 +++
 rtl/stall_ctrl.sv | 131 +++++++++++++
 tb/tb_stall_ctrl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/stall_ctrl_if.sv
// Pipeline-side hazard inputs and stall/flush/memory/muldiv control outputs of stall_ctrl.
// master = pipeline and memory side, slave = stall_ctrl.
interface stall_ctrl_if;
  logic load_stall_i;
  logic branch_EX_i;
  logic dmem_req_MEM_i;
  logic dmem_ready_i;
  logic muldiv_start_EX_i;
  logic muldiv_is_div_i;

  logic dmem_valid_o;
  logic muldiv_busy_o;
  logic muldiv_done_o;
  logic stall_if_o;
  logic stall_id_o;
  logic stall_ex_o;
  logic stall_mem_o;
  logic flush_id_o;
  logic flush_ex_o;
  logic flush_mem_o;
  logic flush_wb_o;
  logic mem_err_o;

  modport master (
    output load_stall_i, branch_EX_i, dmem_req_MEM_i, dmem_ready_i,
           muldiv_start_EX_i, muldiv_is_div_i,
    input  dmem_valid_o, muldiv_busy_o, muldiv_done_o,
           stall_if_o, stall_id_o, stall_ex_o, stall_mem_o,
           flush_id_o, flush_ex_o, flush_mem_o, flush_wb_o, mem_err_o
  );

  modport slave (
    input  load_stall_i, branch_EX_i, dmem_req_MEM_i, dmem_ready_i,
           muldiv_start_EX_i, muldiv_is_div_i,
    output dmem_valid_o, muldiv_busy_o, muldiv_done_o,
           stall_if_o, stall_id_o, stall_ex_o, stall_mem_o,
           flush_id_o, flush_ex_o, flush_mem_o, flush_wb_o, mem_err_o
  );
endinterface

// File: rtl/stall_ctrl.sv
// Pipeline stall/flush controller: memory wait with timeout, multi-cycle mul/div, branch and load-use.
// Outputs are combinational from state and current inputs; a memory wait holds every stage until ready.
module stall_ctrl #(
  parameter int unsigned MUL_CYCLES  = 4,
  parameter int unsigned DIV_CYCLES  = 33,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input logic        clk_i,
  input logic        rst_i,
  stall_ctrl_if.slave bus
);
  localparam int unsigned MD_MAX  = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_MAX = (MD_MAX > MEM_TIMEOUT) ? MD_MAX : MEM_TIMEOUT;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] MEM_TO   = CNT_W'(MEM_TIMEOUT);

  typedef enum logic [1:0] {RUN, MEM_WAIT, MD_BUSY, ERR} state_t;

  state_t           state_q, state_d, cur;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             run_rules;

  logic dmem_valid, md_busy, md_done;
  logic stall_if, stall_id, stall_ex, stall_mem;
  logic flush_id, flush_ex, flush_mem, flush_wb;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RUN;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    // While reset is held the outputs behave as in RUN and nothing advances.
    cur        = rst_i ? RUN : state_q;
    state_d    = cur;
    cnt_d      = cnt_q;
    err_d      = err_q;
    run_rules  = 1'b0;
    dmem_valid = 1'b0;
    md_busy    = 1'b0;
    md_done    = 1'b0;
    stall_if   = 1'b0;
    stall_id   = 1'b0;
    stall_ex   = 1'b0;
    stall_mem  = 1'b0;
    flush_id   = 1'b0;
    flush_ex   = 1'b0;
    flush_mem  = 1'b0;
    flush_wb   = 1'b0;

    unique case (cur)
      RUN: begin
        dmem_valid = bus.dmem_req_MEM_i;
        if (bus.dmem_req_MEM_i && !bus.dmem_ready_i) begin
          {stall_if, stall_id, stall_ex, stall_mem, flush_wb} = '1;
          cnt_d   = CNT_W'(1);
          state_d = MEM_WAIT;
        end else begin
          run_rules = 1'b1;
        end
      end
      MEM_WAIT: begin
        dmem_valid = 1'b1;
        if (!bus.dmem_ready_i) begin
          {stall_if, stall_id, stall_ex, stall_mem, flush_wb} = '1;
          if (cnt_q == MEM_TO) begin
            state_d = ERR;
            err_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          // Release cycle: the held EX/ID stages re-present their hazards now.
          state_d   = RUN;
          run_rules = 1'b1;
        end
      end
      MD_BUSY: begin
        md_busy = 1'b1;
        if (cnt_q == '0) begin
          md_done = 1'b1;
          state_d = RUN;
        end else begin
          {stall_if, stall_id, stall_ex, flush_mem} = '1;
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ERR: begin
        {stall_if, stall_id, stall_ex, stall_mem, flush_wb} = '1;
      end
      default: state_d = RUN;
    endcase

    if (run_rules) begin
      if (bus.muldiv_start_EX_i && !bus.branch_EX_i) begin
        {stall_if, stall_id, stall_ex, flush_mem} = '1;
        cnt_d   = bus.muldiv_is_div_i ? DIV_LOAD : MUL_LOAD;
        state_d = MD_BUSY;
      end else begin
        stall_if = bus.load_stall_i & ~bus.branch_EX_i;
        stall_id = bus.load_stall_i & ~bus.branch_EX_i;
        flush_id = bus.branch_EX_i;
        flush_ex = bus.branch_EX_i | bus.load_stall_i;
      end
    end
  end

  assign bus.dmem_valid_o  = dmem_valid;
  assign bus.muldiv_busy_o = md_busy;
  assign bus.muldiv_done_o = md_done;
  assign bus.stall_if_o    = stall_if;
  assign bus.stall_id_o    = stall_id;
  assign bus.stall_ex_o    = stall_ex;
  assign bus.stall_mem_o   = stall_mem;
  assign bus.flush_id_o    = flush_id;
  assign bus.flush_ex_o    = flush_ex;
  assign bus.flush_mem_o   = flush_mem;
  assign bus.flush_wb_o    = flush_wb;
  assign bus.mem_err_o     = err_q;
endmodule

// File: tb/tb_stall_ctrl.sv
// Bench for stall_ctrl: directed scenarios plus random traffic, scored against a
// cycle-timestamp reference model through an expectation queue.
module tb_stall_ctrl;
  localparam int MUL_N = 4;
  localparam int DIV_N = 33;
  localparam int TO    = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  stall_ctrl_if bus ();

  stall_ctrl #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N), .MEM_TIMEOUT(TO)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct packed {
    bit [11:0] v;
    int        cyc;
    int        phase;
  } exp_t;

  exp_t  exp_q[$];
  int    checks   = 0;
  int    failures = 0;
  int    phase    = 0;
  bit    chk_en   = 1'b0;
  string phase_name [8] = '{"reset", "mem_wait", "mem_then_mul", "div", "mul",
                            "branch_load", "div_reset", "timeout"};

  // Reference model state: absolute cycle stamps rather than a down/up counter.
  int cyc_n    = 0;
  bit m_err    = 1'b0;
  bit m_inmem  = 1'b0;
  bit m_md     = 1'b0;
  int m_mstart = 0;
  int m_done   = 0;

  function automatic bit [11:0] dut_outs();
    return {bus.dmem_valid_o, bus.muldiv_busy_o, bus.muldiv_done_o,
            bus.stall_if_o, bus.stall_id_o, bus.stall_ex_o, bus.stall_mem_o,
            bus.flush_id_o, bus.flush_ex_o, bus.flush_mem_o, bus.flush_wb_o,
            bus.mem_err_o};
  endfunction

  task automatic step(input bit r, input bit ld, input bit br, input bit rq,
                      input bit rd, input bit st, input bit dv);
    bit dvl, bsy, dn, sif, sid, sex, smem, fid, fex, fmem, fwb, inmem, hold;
    exp_t e;
    @(posedge clk);
    #1;
    rst                   = r;
    bus.load_stall_i      = ld;
    bus.branch_EX_i       = br;
    bus.dmem_req_MEM_i    = rq;
    bus.dmem_ready_i      = rd;
    bus.muldiv_start_EX_i = st;
    bus.muldiv_is_div_i   = dv;
    {dvl, bsy, dn, sif, sid, sex, smem, fid, fex, fmem, fwb, hold} = '0;
    inmem = m_inmem && !r;
    if (!r && m_err) begin
      {sif, sid, sex, smem, fwb} = '1;
    end else if (!r && m_md) begin
      bsy = 1'b1;
      if (cyc_n == m_done) dn = 1'b1;
      else {sif, sid, sex, fmem} = '1;
    end else begin
      dvl  = inmem | rq;
      hold = inmem ? !rd : (rq && !rd);
      if (hold) {sif, sid, sex, smem, fwb} = '1;
      else if (st && !br) {sif, sid, sex, fmem} = '1;
      else begin
        sif = ld && !br;
        sid = ld && !br;
        fid = br;
        fex = br || ld;
      end
    end
    e.v     = {dvl, bsy, dn, sif, sid, sex, smem, fid, fex, fmem, fwb, m_err};
    e.cyc   = cyc_n;
    e.phase = phase;
    if (chk_en) exp_q.push_back(e);

    if (r) begin
      m_err = 1'b0; m_inmem = 1'b0; m_md = 1'b0;
    end else if (m_err) begin
      m_err = 1'b1;
    end else if (m_md) begin
      if (cyc_n == m_done) m_md = 1'b0;
    end else if (hold) begin
      if (!m_inmem) begin
        m_inmem  = 1'b1;
        m_mstart = cyc_n;
      end else if (cyc_n - m_mstart == TO) begin
        m_err   = 1'b1;
        m_inmem = 1'b0;
      end
    end else begin
      m_inmem = 1'b0;
      if (st && !br) begin
        m_md   = 1'b1;
        m_done = cyc_n + (dv ? DIV_N : MUL_N);
      end
    end
    cyc_n++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 1, 0, 0);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      bit [11:0] act;
      e   = exp_q.pop_front();
      act = dut_outs();
      checks++;
      if (act !== e.v) begin
        failures++;
        $display("FAIL %s cyc=%0d outs actual=%b expected=%b (dvl,bsy,dn,sif,sid,sex,smem,fid,fex,fmem,fwb,err)",
                 phase_name[e.phase], e.cyc, act, e.v);
      end
    end
  end

  initial begin
    bus.load_stall_i      = 1'b0;
    bus.branch_EX_i       = 1'b0;
    bus.dmem_req_MEM_i    = 1'b0;
    bus.dmem_ready_i      = 1'b1;
    bus.muldiv_start_EX_i = 1'b0;
    bus.muldiv_is_div_i   = 1'b0;

    phase = 0;
    step(1, 0, 0, 0, 1, 0, 0);
    chk_en = 1'b1;
    step(1, 0, 0, 0, 1, 0, 0);
    step(1, 1, 0, 1, 1, 0, 0);
    idle(2);

    phase = 1;
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0, 0);
    idle(2);

    phase = 2;
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 1, 0);
    step(0, 0, 0, 1, 1, 1, 0);
    for (int i = 0; i < MUL_N - 1; i++) step(0, 0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    idle(2);

    phase = 3;
    for (int i = 0; i < DIV_N; i++) step(0, 0, 0, 0, 1, 1, 1);
    step(0, 0, 0, 0, 1, 0, 1);
    idle(2);

    phase = 4;
    for (int i = 0; i < MUL_N; i++) step(0, 0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    idle(2);

    phase = 5;
    step(0, 1, 1, 0, 1, 0, 0);
    step(0, 0, 1, 0, 1, 1, 1);
    step(0, 1, 0, 0, 1, 0, 0);
    idle(1);

    phase = 6;
    for (int i = 0; i < 9; i++) step(0, 0, 0, 0, 1, 1, 1);
    step(1, 0, 0, 0, 1, 1, 1);
    idle(3);

    phase = 7;
    for (int i = 0; i < 8; i++) step(0, i[0], i[1], 1, 0, i[2], 0);
    step(1, 0, 0, 1, 0, 0, 0);
    idle(3);

    phase = 0;
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) < 2), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 4) == 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 9) < 6), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 3) == 0));
    end
    idle(1);

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending actual=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
